// File: rtl/nios2_cpu_cpu_mult_pipe.sv
// Two-stage pipelined WIDTH x WIDTH multiplier for Nios II MUL/MULXSS/MULXSU/MULXUU.
// Optional signed-overflow flag for MUL is enabled by defining NIOS2_MULT_OVF_FLAG_EN.
module nios2_cpu_cpu_mult_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic [1:0]       E_op,
  input  logic             E_valid,
  input  logic             M_en,
  output logic [WIDTH-1:0] W_mul_result,
  output logic             W_mul_valid,
  output logic             W_mul_ovf
);

  localparam int HALF = WIDTH / 2;

  function automatic logic [WIDTH-1:0] mul_half(input logic [HALF-1:0] x,
                                                input logic [HALF-1:0] y);
    return WIDTH'(x) * WIDTH'(y);
  endfunction

  // Unsigned partial products recombined; signedness folded in via corr in the upper word.
  function automatic logic [2*WIDTH-1:0] combine(input logic [WIDTH-1:0] ll,
                                                 input logic [WIDTH-1:0] lh,
                                                 input logic [WIDTH-1:0] hl,
                                                 input logic [WIDTH-1:0] hh,
                                                 input logic [WIDTH-1:0] cr);
    logic [WIDTH:0] mid;
    mid = {1'b0, lh} + {1'b0, hl};
    return {{WIDTH{1'b0}}, ll}
         + ({{(WIDTH-1){1'b0}}, mid} << HALF)
         + {hh, {WIDTH{1'b0}}}
         - {cr, {WIDTH{1'b0}}};
  endfunction

  logic             s_a, s_b;
  logic [WIDTH-1:0] corr;

  always_comb begin
    s_a  = E_src1[WIDTH-1] & (E_op != 2'b11);
    s_b  = E_src2[WIDTH-1] & ~E_op[1];
    corr = (s_a ? E_src2 : '0) + (s_b ? E_src1 : '0);
  end

  // E -> M boundary
  logic [WIDTH-1:0] p_ll_p1, p_lh_p1, p_hl_p1, p_hh_p1, corr_p1;
  logic [1:0]       op_p1;
  logic             vld_p1;

  always_ff @(posedge clk) begin
    if (reset)     vld_p1 <= 1'b0;
    else if (M_en) vld_p1 <= E_valid;
  end

  always_ff @(posedge clk) begin
    if (M_en) begin
      p_ll_p1 <= mul_half(E_src1[HALF-1:0],     E_src2[HALF-1:0]);
      p_lh_p1 <= mul_half(E_src1[HALF-1:0],     E_src2[WIDTH-1:HALF]);
      p_hl_p1 <= mul_half(E_src1[WIDTH-1:HALF], E_src2[HALF-1:0]);
      p_hh_p1 <= mul_half(E_src1[WIDTH-1:HALF], E_src2[WIDTH-1:HALF]);
      corr_p1 <= corr;
      op_p1   <= E_op;
    end
  end

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = combine(p_ll_p1, p_lh_p1, p_hl_p1, p_hh_p1, corr_p1);
  end

  // M -> W boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      W_mul_result <= '0;
      W_mul_valid  <= 1'b0;
    end else if (M_en) begin
      W_mul_result <= (op_p1 == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      W_mul_valid  <= vld_p1;
    end
  end

`ifdef NIOS2_MULT_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)     W_mul_ovf <= 1'b0;
    else if (M_en) W_mul_ovf <= (op_p1 == 2'b00) &&
                                (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
  end
`else
  assign W_mul_ovf = 1'b0;
`endif

endmodule
